// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Multicycle fetch stage and instruction register for the RV32I core.
// One instruction word is fetched per instruction. The word is latched and
// its opcode is classified into the 3-bit immediate-format code. The latched
// instruction, pc and format stay frozen until execute hands back next_pc.
//
// Sequence: BOOT -> FETCH -> DECODE -> HOLD -> FETCH ...
// A misaligned next_pc moves the unit to TRAP, which it leaves only on reset.
//
// Parameters
//   XLEN      data/address width
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   mem_req       fetch request to instruction memory (state FETCH)
//   mem_addr      fetch address, always equal to pc
//   mem_ready     mem_rdata valid this cycle (sampled only in FETCH)
//   mem_rdata     fetched word
//   next_pc_valid execute done, next_pc valid (sampled only in HOLD)
//   next_pc       address of the next instruction
//   pc            address of the held instruction
//   instruction   instruction register
//   imm_fmt       0=I 1=S 2=B 3=U 4=J 7=none/illegal
//   instr_valid   instruction/imm_fmt/pc valid and stable (state HOLD)
//   illegal       held instruction has an unsupported opcode
//   fault         misaligned next_pc trapped, sticky until reset
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             next_pc_valid,
    input  logic [XLEN-1:0]  next_pc,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  instruction,
    output logic [2:0]       imm_fmt,
    output logic             instr_valid,
    output logic             illegal,
    output logic             fault
);

    // Immediate-format codes.
    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_NONE = 3'd7;

    // The instruction register resets to a canonical NOP (addi x0,x0,0).
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        HOLD   = 3'd3,
        TRAP   = 3'd4
    } state_t;

    // Result of classifying one opcode.
    typedef struct packed {
        logic       illegal;
        logic [2:0] fmt;
    } dec_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  instr_q;
    logic [2:0]       fmt_q;
    logic             illegal_q;
    dec_t             dec;
    logic             npc_aligned;

    // -----------------------------------------------------------------------
    // Opcode classifier. Anything whose low two bits are not 2'b11 is a
    // compressed or invalid encoding and falls into the illegal default.
    // R-type has no immediate but is a legal instruction.
    // -----------------------------------------------------------------------
    function automatic dec_t classify(input logic [6:0] opcode);
        dec_t d;
        d.illegal = 1'b0;
        d.fmt     = FMT_NONE;
        case (opcode)
            7'b0000011,                       // loads
            7'b0010011,                       // ALU immediate
            7'b1100111,                       // jalr
            7'b1110011,                       // system
            7'b0001111: d.fmt = FMT_I;        // fence
            7'b0100011: d.fmt = FMT_S;        // stores
            7'b1100011: d.fmt = FMT_B;        // branches
            7'b0110111,                       // lui
            7'b0010111: d.fmt = FMT_U;        // auipc
            7'b1101111: d.fmt = FMT_J;        // jal
            7'b0110011: d.fmt = FMT_NONE;     // R-type, legal
            default: begin
                d.fmt     = FMT_NONE;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    assign dec         = classify(instr_q[6:0]);
    assign npc_aligned = (next_pc[1:0] == 2'b00);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. mem_ready only matters in FETCH and next_pc_valid
    // only in HOLD; everywhere else they are ignored by construction.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:   state_d = FETCH;
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: state_d = HOLD;
            HOLD: begin
                if (next_pc_valid) begin
                    state_d = npc_aligned ? FETCH : TRAP;
                end
            end
            TRAP:   state_d = TRAP;
            default: state_d = BOOT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers. Each one has exactly one state in which it may
    // change, so everything is frozen while HOLD waits on execute.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            fmt_q     <= FMT_I;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ready) begin
                        instr_q <= mem_rdata;
                    end
                end
                DECODE: begin
                    fmt_q     <= dec.fmt;
                    illegal_q <= dec.illegal;
                end
                HOLD: begin
                    // A misaligned target traps with pc left at the
                    // instruction that produced it.
                    if (next_pc_valid && npc_aligned) begin
                        pc_q <= next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: registers or pure decodes of the state register, so none of
    // them depends combinationally on an input.
    // -----------------------------------------------------------------------
    assign mem_req     = (state_q == FETCH);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign imm_fmt     = fmt_q;
    assign illegal     = illegal_q;
    assign instr_valid = (state_q == HOLD);
    assign fault       = (state_q == TRAP);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit: reset values, boot timing with a
// zero-wait memory, wait states, the opcode-to-format table, next_pc
// handling, misaligned trap and asynchronous reset in the middle of a fetch.
// Inputs are driven and outputs sampled 2 time units after a rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic             clk;
    logic             rst_n;
    logic             mem_req;
    logic [XLEN-1:0]  mem_addr;
    logic             mem_ready;
    logic [XLEN-1:0]  mem_rdata;
    logic             next_pc_valid;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instruction;
    logic [2:0]       imm_fmt;
    logic             instr_valid;
    logic             illegal;
    logic             fault;

    int n_chk;
    int n_err;

    instruction_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .next_pc_valid (next_pc_valid),
        .next_pc       (next_pc),
        .pc            (pc),
        .instruction   (instruction),
        .imm_fmt       (imm_fmt),
        .instr_valid   (instr_valid),
        .illegal       (illegal),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // All outputs at their reset values.
    task automatic chk_reset_outs(input string tag);
        chk({tag, ".mem_req"},     32'(mem_req),     32'd0);
        chk({tag, ".mem_addr"},    mem_addr,         RESET_PC);
        chk({tag, ".pc"},          pc,               RESET_PC);
        chk({tag, ".instruction"}, instruction,      NOP);
        chk({tag, ".imm_fmt"},     32'(imm_fmt),     32'd0);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".illegal"},     32'(illegal),     32'd0);
        chk({tag, ".fault"},       32'(fault),       32'd0);
    endtask

    // From HOLD: hand back npc, fetch word with zero wait, land in HOLD.
    task automatic run_instr(input logic [31:0] npc, input logic [31:0] word,
                             input logic [2:0] exp_fmt, input logic exp_ill);
        next_pc_valid = 1'b1;
        next_pc       = npc;
        mem_ready     = 1'b1;
        mem_rdata     = word;
        cyc();                                   // now FETCH
        next_pc_valid = 1'b0;
        chk("sweep.pc",      pc,               npc);
        chk("sweep.mem_req", 32'(mem_req),     32'd1);
        chk("sweep.ivalid0", 32'(instr_valid), 32'd0);
        cyc();                                   // DECODE
        chk("sweep.instr",   instruction,      word);
        cyc();                                   // HOLD
        chk("sweep.ivalid1", 32'(instr_valid), 32'd1);
        chk("sweep.fmt",     32'(imm_fmt),     32'(exp_fmt));
        chk("sweep.illegal", 32'(illegal),     32'(exp_ill));
    endtask

    logic [6:0] sw_op  [8];
    logic [2:0] sw_fmt [8];
    logic       sw_ill [8];

    initial begin
        n_chk = 0;
        n_err = 0;
        sw_op[0] = 7'b0100011; sw_fmt[0] = 3'd1; sw_ill[0] = 1'b0;
        sw_op[1] = 7'b1100011; sw_fmt[1] = 3'd2; sw_ill[1] = 1'b0;
        sw_op[2] = 7'b0110111; sw_fmt[2] = 3'd3; sw_ill[2] = 1'b0;
        sw_op[3] = 7'b0010111; sw_fmt[3] = 3'd3; sw_ill[3] = 1'b0;
        sw_op[4] = 7'b1101111; sw_fmt[4] = 3'd4; sw_ill[4] = 1'b0;
        sw_op[5] = 7'b0110011; sw_fmt[5] = 3'd7; sw_ill[5] = 1'b0;
        sw_op[6] = 7'b1111111; sw_fmt[6] = 3'd7; sw_ill[6] = 1'b1;
        sw_op[7] = 7'b0000000; sw_fmt[7] = 3'd7; sw_ill[7] = 1'b1;

        rst_n         = 1'b1;
        mem_ready     = 1'b1;
        mem_rdata     = 32'h0050_0093;
        next_pc_valid = 1'b0;
        next_pc       = '0;
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outs("reset");

        // Boot with a zero-wait memory.
        @(posedge clk);
        #2 rst_n = 1'b1;                        // cycle 1: BOOT
        chk("boot.c1.mem_req", 32'(mem_req), 32'd0);
        cyc();                                   // cycle 2: FETCH
        chk("boot.c2.mem_req",  32'(mem_req), 32'd1);
        chk("boot.c2.mem_addr", mem_addr,     32'h0);
        cyc();                                   // cycle 3: DECODE
        chk("boot.c3.instr",   instruction,      32'h0050_0093);
        chk("boot.c3.mem_req", 32'(mem_req),     32'd0);
        chk("boot.c3.ivalid",  32'(instr_valid), 32'd0);
        cyc();                                   // cycle 4: HOLD
        chk("boot.c4.ivalid",  32'(instr_valid), 32'd1);
        chk("boot.c4.fmt",     32'(imm_fmt),     32'd0);
        chk("boot.c4.illegal", 32'(illegal),     32'd0);

        // Accept next_pc=0x104, then 5 wait states with stray next_pc pulses.
        next_pc_valid = 1'b1;
        next_pc       = 32'h0000_0104;
        cyc();                                   // FETCH
        chk("npc.pc",       pc,               32'h0000_0104);
        chk("npc.mem_addr", mem_addr,         32'h0000_0104);
        chk("npc.ivalid",   32'(instr_valid), 32'd0);
        chk("npc.mem_req",  32'(mem_req),     32'd1);
        mem_ready = 1'b0;
        mem_rdata = 32'h0000_0023;
        next_pc   = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            next_pc_valid = (i == 1);
            cyc();
            chk("wait.mem_req",  32'(mem_req), 32'd1);
            chk("wait.mem_addr", mem_addr,     32'h0000_0104);
            chk("wait.instr",    instruction,  32'h0050_0093);
        end
        next_pc_valid = 1'b0;
        mem_ready     = 1'b1;
        cyc();                                   // DECODE
        chk("wait.instr_upd", instruction, 32'h0000_0023);
        next_pc_valid = 1'b1;                    // ignored in DECODE
        mem_rdata     = 32'hdead_beef;           // ignored outside FETCH
        cyc();                                   // HOLD
        next_pc_valid = 1'b0;
        chk("decode.ign.pc",    pc,               32'h0000_0104);
        chk("decode.ign.fmt",   32'(imm_fmt),     32'd1);
        chk("decode.ign.instr", instruction,      32'h0000_0023);
        cyc();                                   // still HOLD
        chk("hold.stay.ivalid", 32'(instr_valid), 32'd1);
        chk("hold.stay.mreq",   32'(mem_req),     32'd0);

        // Opcode sweep.
        for (int i = 0; i < 8; i++) begin
            run_instr(32'h0000_1000 + 32'(i * 4), {25'h0AB_CD00 >> 1, sw_op[i]},
                      sw_fmt[i], sw_ill[i]);
        end

        // Misaligned next_pc traps.
        next_pc_valid = 1'b1;
        next_pc       = 32'h0000_0102;
        cyc();
        next_pc_valid = 1'b0;
        chk("trap.fault",  32'(fault),       32'd1);
        chk("trap.ivalid", 32'(instr_valid), 32'd0);
        chk("trap.pc",     pc,               32'h0000_101C);
        for (int i = 0; i < 4; i++) begin
            next_pc_valid = 1'b1;
            next_pc       = 32'h0000_0200;
            cyc();
            chk("trap.mem_req", 32'(mem_req), 32'd0);
            chk("trap.sticky",  32'(fault),   32'd1);
        end
        next_pc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("trap.reset");

        // Restart, fetch a jal, then reset asynchronously mid-FETCH.
        mem_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();                                   // FETCH
        chk("re.mem_req",  32'(mem_req), 32'd1);
        chk("re.mem_addr", mem_addr,     RESET_PC);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_006F;
        cyc();
        cyc();                                   // HOLD
        chk("re.fmt", 32'(imm_fmt), 32'd4);
        next_pc_valid = 1'b1;
        next_pc       = 32'h0000_0040;
        mem_ready     = 1'b0;
        cyc();                                   // FETCH @0x40
        next_pc_valid = 1'b0;
        chk("mid.pc", pc, 32'h0000_0040);
        cyc();
        #3 rst_n = 1'b0;                         // between edges
        #1;
        chk_reset_outs("mid.async");
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        cyc();
        chk("mid.held.instr", instruction, NOP);
        rst_n     = 1'b1;                        // BOOT
        mem_ready = 1'b0;
        cyc();                                   // FETCH
        chk("mid.rel.mem_req",  32'(mem_req), 32'd1);
        chk("mid.rel.mem_addr", mem_addr,     RESET_PC);
        chk("mid.rel.instr",    instruction,  NOP);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
